// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - Default widths and the memory-wait timeout used by pipe_hazard_ctrl.
//   - Encoding of the memory-access FSM states.
package riscv_pipe_pkg;

  localparam int DEF_REGINDEX = 5;
  localparam int DEF_TIMEOUT  = 255;
  localparam int DEF_CNTW     = 16;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset, clears the count
//   inc   - add one this cycle unless already at all-ones
//   clr   - synchronous clear, wins over inc
//   count - current value
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a five-stage pipeline. Decides, each cycle, whether
// the PC and stage registers load, stall or take a bubble, based on data-memory
// waits, EX-stage redirects and load-use dependencies. Also keeps stall/flush
// performance counters and a sticky memory-timeout flag.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   id_rs1/id_rs2, *_used         - sources read by the ID instruction
//   ex_rd, ex_load                - destination and load flag of the EX instruction
//   ex_redirect                   - taken branch/jump resolved in EX
//   mem_access, dmem_ready        - EX/MEM holds a memory op / memory completes it
//   dmem_req                      - data-memory request
//   pc_en .. memwb_en             - load enables for PC and stage registers
//   ifid_flush, idex_flush        - stage register loads a NOP next edge
//   perf_clr                      - clears the performance counters
//   stall_cnt, flush_cnt          - saturating counters of stall / redirect cycles
//   mem_err                       - set by a memory timeout, cleared only by rst
module pipe_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int REGINDEX = DEF_REGINDEX,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int CNTW     = DEF_CNTW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REGINDEX-1:0] id_rs1,
  input  logic [REGINDEX-1:0] id_rs2,
  input  logic                id_rs1_used,
  input  logic                id_rs2_used,
  input  logic [REGINDEX-1:0] ex_rd,
  input  logic                ex_load,
  input  logic                ex_redirect,
  input  logic                mem_access,
  input  logic                dmem_ready,
  output logic                dmem_req,
  output logic                pc_en,
  output logic                ifid_en,
  output logic                idex_en,
  output logic                exmem_en,
  output logic                memwb_en,
  output logic                ifid_flush,
  output logic                idex_flush,
  input  logic                perf_clr,
  output logic [CNTW-1:0]     stall_cnt,
  output logic [CNTW-1:0]     flush_cnt,
  output logic                mem_err
);

  localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  hz_state_e      state_q, state_d;
  logic [WCW-1:0] wait_cnt;
  logic           access_active;
  logic           timeout_hit;
  logic           freeze;
  logic           load_use;
  logic           redirect_cycle;

  // A timed-out access releases the freeze in the same cycle so the pipeline
  // moves on instead of hanging on a dead memory.
  always_comb begin
    access_active = ((state_q == RUN) && mem_access) || (state_q == MEM_WAIT);
    timeout_hit   = (state_q == MEM_WAIT) && (wait_cnt == WAIT_LAST) && !dmem_ready;
    freeze        = access_active && !dmem_ready && !timeout_hit;
    load_use      = ex_load && (ex_rd != '0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));
    redirect_cycle = !rst && !freeze && ex_redirect;
  end

  // Next state and pipeline controls. Redirect and load-use are simply not
  // acted on while frozen; their inputs are held by the frozen stages, so they
  // take effect on the cycle the freeze lifts.
  always_comb begin
    state_d    = state_q;
    dmem_req   = 1'b0;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;

    case (state_q)
      RUN:      if (mem_access && !dmem_ready) state_d = MEM_WAIT;
      MEM_WAIT: if (dmem_ready || timeout_hit) state_d = RUN;
    endcase

    if (rst) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      dmem_req = access_active;
      if (freeze) begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
      end else if (ex_redirect) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        // The bubble clears ex_load in EX, so only one stall per load.
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  // wait_cnt is held at zero in RUN so it always starts from zero on entry
  // to MEM_WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == RUN) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + WCW'(1);
      end
      if (timeout_hit) begin
        mem_err <= 1'b1;
      end
    end
  end

  sat_counter #(.WIDTH(CNTW)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (!pc_en),
    .clr   (perf_clr),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNTW)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (redirect_cycle),
    .clr   (perf_clr),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a table of single-cycle control
// vectors plus hand-written sequences for memory waits, deferred redirects,
// timeout, reset during a wait and counter saturation/clear.
module tb_pipe_hazard_ctrl;

  localparam int REGINDEX = 5;
  localparam int TIMEOUT  = 4;
  localparam int CNTW     = 4;

  // Expected control word bit order:
  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, dmem_req}
  localparam logic [7:0] C_NORM   = 8'hF8;
  localparam logic [7:0] C_NORM_R = 8'hF9;
  localparam logic [7:0] C_LU     = 8'h3A;
  localparam logic [7:0] C_LU_R   = 8'h3B;
  localparam logic [7:0] C_REDIR  = 8'hFE;
  localparam logic [7:0] C_REDIR_R= 8'hFF;
  localparam logic [7:0] C_FREEZE = 8'h01;
  localparam logic [7:0] C_RESET  = 8'h06;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [REGINDEX-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic                id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic                ex_load = 1'b0, ex_redirect = 1'b0;
  logic                mem_access = 1'b0, dmem_ready = 1'b1;
  logic                perf_clr = 1'b0;
  logic                dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic                ifid_flush, idex_flush, mem_err;
  logic [CNTW-1:0]     stall_cnt, flush_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       ld;
    logic       redir;
    logic       macc;
    logic       rdy;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REGINDEX(REGINDEX),
    .TIMEOUT (TIMEOUT),
    .CNTW    (CNTW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used),
    .ex_rd      (ex_rd),
    .ex_load    (ex_load),
    .ex_redirect(ex_redirect),
    .mem_access (mem_access),
    .dmem_ready (dmem_ready),
    .dmem_req   (dmem_req),
    .pc_en      (pc_en),
    .ifid_en    (ifid_en),
    .idex_en    (idex_en),
    .exmem_en   (exmem_en),
    .memwb_en   (memwb_en),
    .ifid_flush (ifid_flush),
    .idex_flush (idex_flush),
    .perf_clr   (perf_clr),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt),
    .mem_err    (mem_err)
  );

  function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic [4:0] rd,
                              input logic ld, input logic redir, input logic macc,
                              input logic rdy, input logic [7:0] exp);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
    v.ld = ld; v.redir = redir; v.macc = macc; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  function automatic logic [7:0] ctl();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, dmem_req};
  endfunction

  // Drive one cycle's inputs on the falling edge; outputs settle 1 time unit later.
  task automatic apply_stimulus(input vec_t v, input logic clr, input logic rst_v);
    @(negedge clk);
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_rs1_used = v.u1; id_rs2_used = v.u2;
    ex_rd = v.rd; ex_load = v.ld; ex_redirect = v.redir;
    mem_access = v.macc; dmem_ready = v.rdy;
    perf_clr = clr; rst = rst_v;
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  initial begin
    vec_t idle, lu, mwait, redir_wait;
    int exp_stall, exp_flush;

    idle       = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, C_NORM);
    lu         = mk(5, 0, 1, 0, 5, 1, 0, 0, 1, C_LU);
    mwait      = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_FREEZE);
    redir_wait = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, C_FREEZE);

    vecs[0] = mk(1, 2, 1, 1, 3, 0, 0, 0, 1, C_NORM);
    vecs[1] = mk(5, 0, 1, 0, 5, 1, 0, 0, 1, C_LU);
    vecs[2] = mk(3, 7, 1, 1, 7, 1, 0, 0, 1, C_LU);
    vecs[3] = mk(5, 5, 0, 0, 5, 1, 0, 0, 1, C_NORM);
    vecs[4] = mk(0, 0, 1, 1, 0, 1, 0, 0, 1, C_NORM);
    vecs[5] = mk(9, 0, 1, 0, 9, 0, 0, 0, 1, C_NORM);
    vecs[6] = mk(1, 2, 1, 1, 3, 0, 1, 0, 1, C_REDIR);
    vecs[7] = mk(4, 0, 1, 0, 4, 1, 1, 0, 1, C_REDIR);
    vecs[8] = mk(1, 2, 1, 1, 3, 0, 0, 1, 1, C_NORM_R);
    vecs[9] = mk(6, 6, 0, 1, 6, 1, 0, 1, 1, C_LU_R);

    // Reset: outputs forced even with a memory op pending.
    apply_stimulus(mwait, 1'b0, 1'b1);
    check_output("reset_ctl", ctl(), C_RESET);
    apply_stimulus(idle, 1'b0, 1'b0);
    check_output("reset_stall_cnt", stall_cnt, 0);
    check_output("reset_flush_cnt", flush_cnt, 0);
    check_output("reset_mem_err", mem_err, 0);
    check_output("post_reset_ctl", ctl(), C_NORM);

    // Vector table.
    apply_stimulus(idle, 1'b1, 1'b0);
    exp_stall = 0;
    exp_flush = 0;
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i], 1'b0, 1'b0);
      check_output($sformatf("vec%0d_ctl", i), ctl(), vecs[i].exp);
      if (!vecs[i].exp[7]) exp_stall++;
      if (vecs[i].exp[2]) exp_flush++;
    end
    apply_stimulus(idle, 1'b0, 1'b0);
    check_output("table_stall_cnt", stall_cnt, exp_stall);
    check_output("table_flush_cnt", flush_cnt, exp_flush);

    // Load-use: exactly one bubble.
    apply_stimulus(idle, 1'b1, 1'b0);
    apply_stimulus(lu, 1'b0, 1'b0);
    check_output("lu_ctl", ctl(), C_LU);
    apply_stimulus(idle, 1'b0, 1'b0);
    check_output("lu_bubble_ctl", ctl(), C_NORM);
    check_output("lu_stall_cnt", stall_cnt, 1);

    // Memory wait of three cycles.
    apply_stimulus(idle, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(mwait, 1'b0, 1'b0);
      check_output($sformatf("mwait%0d_ctl", i), ctl(), C_FREEZE);
    end
    apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, C_NORM_R), 1'b0, 1'b0);
    check_output("mwait_release_ctl", ctl(), C_NORM_R);
    apply_stimulus(idle, 1'b0, 1'b0);
    check_output("mwait_idle_ctl", ctl(), C_NORM);
    check_output("mwait_stall_cnt", stall_cnt, 3);

    // Redirect deferred by a freeze.
    apply_stimulus(idle, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(redir_wait, 1'b0, 1'b0);
      check_output($sformatf("redir_frz%0d_ctl", i), ctl(), C_FREEZE);
    end
    apply_stimulus(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, C_REDIR_R), 1'b0, 1'b0);
    check_output("redir_ready_ctl", ctl(), C_REDIR_R);
    apply_stimulus(idle, 1'b0, 1'b0);
    check_output("redir_flush_cnt", flush_cnt, 1);
    check_output("redir_stall_cnt", stall_cnt, 2);

    // Timeout: 1 RUN freeze cycle, then MEM_WAIT counts 0..3; the 4th aborts.
    apply_stimulus(idle, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(mwait, 1'b0, 1'b0);
      check_output($sformatf("tmo_frz%0d_ctl", i), ctl(), C_FREEZE);
    end
    apply_stimulus(mwait, 1'b0, 1'b0);
    check_output("tmo_hit_ctl", ctl(), C_NORM_R);
    check_output("tmo_hit_mem_err", mem_err, 0);
    apply_stimulus(idle, 1'b0, 1'b0);
    check_output("tmo_after_ctl", ctl(), C_NORM);
    check_output("tmo_mem_err", mem_err, 1);
    check_output("tmo_stall_cnt", stall_cnt, 4);
    apply_stimulus(idle, 1'b0, 1'b0);
    check_output("tmo_mem_err_sticky", mem_err, 1);

    // Reset in the would-be timeout cycle: no mem_err, back in RUN.
    apply_stimulus(idle, 1'b0, 1'b1);
    apply_stimulus(idle, 1'b0, 1'b0);
    check_output("rst_clears_mem_err", mem_err, 0);
    for (int i = 0; i < 4; i++) apply_stimulus(mwait, 1'b0, 1'b0);
    apply_stimulus(mwait, 1'b0, 1'b1);
    check_output("rst_in_wait_ctl", ctl(), C_RESET);
    apply_stimulus(idle, 1'b0, 1'b0);
    check_output("rst_in_wait_mem_err", mem_err, 0);
    check_output("rst_in_wait_run_ctl", ctl(), C_NORM);
    check_output("rst_in_wait_stall_cnt", stall_cnt, 0);

    // Saturation and clear-over-increment.
    apply_stimulus(idle, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) apply_stimulus(lu, 1'b0, 1'b0);
    apply_stimulus(idle, 1'b0, 1'b0);
    check_output("sat_stall_cnt", stall_cnt, 15);
    apply_stimulus(lu, 1'b1, 1'b0);
    apply_stimulus(idle, 1'b0, 1'b0);
    check_output("clr_over_inc_stall_cnt", stall_cnt, 0);
    for (int i = 0; i < 20; i++) apply_stimulus(vecs[6], 1'b0, 1'b0);
    apply_stimulus(idle, 1'b0, 1'b0);
    check_output("sat_flush_cnt", flush_cnt, 15);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
